// File: rtl/ins_assembler.sv
// ins_assembler: packs instruction fields into 32-bit MIPS words (R, I, J) and
// writes them to instruction memory at consecutive, wrapping word addresses.
//
// Optional build macro: INS_ASM_CHECK_EN
//   defined   : fmt=3 writes a nop (32'h0) and sets the sticky err flag.
//   undefined : fmt=3 is encoded as J format and err is tied to 0.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               begins a program load (sampled only in IDLE)
//   base_addr, count    first word address and word count, sampled with start
//   in_valid, in_ready  field-bundle handshake
//   fmt, op, func, rs, rt, rd, shamt, imm16, target   instruction fields
//   we, waddr, wdata    instruction-memory write port
//   busy, done, err     load status

module ins_assembler #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        op,
  input  logic [5:0]        func,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm16,
  input  logic [25:0]       target,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StWrite = 2'd2,
    StFin   = 2'd3
  } state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_rem;
  logic                r_in_ready;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [31:0]         r_wdata;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic [31:0]         w_word;
  logic                w_illegal;

  // Field encoder
  always_comb begin
    w_word    = {op, target};
    w_illegal = 1'b0;
    unique case (fmt)
      2'd0: w_word = {op, rs, rt, rd, shamt, func};
      2'd1: w_word = {op, rs, rt, imm16};
      2'd2: w_word = {op, target};
      2'd3: begin
`ifdef INS_ASM_CHECK_EN
        w_word    = 32'h0000_0000;
        w_illegal = 1'b1;
`else
        w_word    = {op, target};
`endif
      end
      default: w_word = {op, target};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_rem      <= '0;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_addr <= base_addr;
            r_rem  <= count;
            r_err  <= 1'b0;
            if (count == '0) begin
              r_state <= StFin;
              r_done  <= 1'b1;
            end else begin
              r_state    <= StLoad;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (in_valid) begin
            r_state    <= StWrite;
            r_in_ready <= 1'b0;
            r_we       <= 1'b1;
            r_waddr    <= r_addr;
            r_wdata    <= w_word;
            if (w_illegal) r_err <= 1'b1;
          end
        end
        StWrite: begin
          r_addr <= r_addr + 1'b1;
          r_rem  <= r_rem - 1'b1;
          if (r_rem == (ADDR_W+1)'(1)) begin
            r_state <= StFin;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state    <= StLoad;
            r_in_ready <= 1'b1;
          end
        end
        StFin: begin
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign we       = r_we;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;
  assign busy     = r_busy;
  assign done     = r_done;
`ifdef INS_ASM_CHECK_EN
  assign err      = r_err;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_ins_assembler.sv
module tb_ins_assembler;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    fmt;
  logic [5:0]    op, func;
  logic [4:0]    rs, rt, rd, shamt;
  logic [15:0]   imm16;
  logic [25:0]   target;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          busy, done, err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [AW-1:0] exp_addr;
  int            exp_rem;
  logic          exp_err;

  ins_assembler #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .op(op), .func(func),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm16(imm16), .target(target),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Instruction word as defined by the format rules
  function automatic logic [31:0] enc(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s,
                                      input logic [4:0] t, input logic [4:0] d,
                                      input logic [4:0] sh, input logic [5:0] fn,
                                      input logic [15:0] im, input logic [25:0] tg);
    logic [31:0] w;
    if (f == 2'd0)      w = (32'(o) << 26) | (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11)
                            | (32'(sh) << 6) | 32'(fn);
    else if (f == 2'd1) w = (32'(o) << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
    else if (f == 2'd2) w = (32'(o) << 26) | 32'(tg);
    else begin
`ifdef INS_ASM_CHECK_EN
      w = 32'h0;
`else
      w = (32'(o) << 26) | 32'(tg);
`endif
    end
    return w;
  endfunction

  task automatic do_start(input logic [AW-1:0] b, input int cnt);
    start = 1'b1;
    base_addr = b;
    count = (AW+1)'(cnt);
    tick();
    start = 1'b0;
    base_addr = AW'($urandom);
    count = (AW+1)'($urandom);
    exp_addr = b;
    exp_rem = cnt;
    exp_err = 1'b0;
    if (cnt == 0) begin
      chk("zero_done", done, 1);
      chk("zero_we", we, 0);
      chk("zero_ready", in_ready, 0);
      chk("zero_busy", busy, 0);
      chk("zero_err", err, 0);
      tick();
      chk("zero_done_end", done, 0);
      chk("zero_ready_end", in_ready, 0);
      chk("zero_we_end", we, 0);
    end else begin
      chk("start_busy", busy, 1);
      chk("start_ready", in_ready, 1);
      chk("start_done", done, 0);
      chk("start_err", err, 0);
    end
  endtask

  task automatic send_word(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s,
                           input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                           input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg,
                           input logic [31:0] exp_word, input int idle, input bit ign_start);
    for (int i = 0; i < idle; i++) begin
      in_valid = 1'b0;
      if (ign_start && i == 0) begin
        start = 1'b1;
        base_addr = AW'($urandom);
        count = (AW+1)'($urandom);
      end
      tick();
      start = 1'b0;
      chk("bp_ready", in_ready, 1);
      chk("bp_we", we, 0);
      chk("bp_busy", busy, 1);
    end
    chk("pre_ready", in_ready, 1);
    fmt = f; op = o; rs = s; rt = t; rd = d; shamt = sh; func = fn; imm16 = im; target = tg;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef INS_ASM_CHECK_EN
    if (f == 2'd3) exp_err = 1'b1;
`endif
    chk("we", we, 1);
    chk("waddr", waddr, exp_addr);
    chk("wdata", wdata, exp_word);
    chk("wr_ready", in_ready, 0);
    chk("wr_err", err, exp_err);
    exp_addr = exp_addr + 1'b1;
    exp_rem--;
    tick();
    chk("post_we", we, 0);
    chk("post_err", err, exp_err);
    if (exp_rem == 0) begin
      chk("done", done, 1);
      chk("done_busy", busy, 0);
      chk("done_ready", in_ready, 0);
      tick();
      chk("done_end", done, 0);
      chk("idle_ready", in_ready, 0);
      chk("idle_err", err, exp_err);
    end else begin
      chk("next_ready", in_ready, 1);
      chk("next_done", done, 0);
    end
  endtask

  initial begin
    logic [1:0]  f;
    logic [5:0]  o, fn;
    logic [4:0]  s, t, d, sh;
    logic [15:0] im;
    logic [25:0] tg;
    int          n;
    logic [31:0] ill_word;

    rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0;
    fmt = '0; op = '0; func = '0; rs = '0; rt = '0; rd = '0; shamt = '0;
    imm16 = '0; target = '0;
    exp_addr = '0; exp_rem = 0; exp_err = 1'b0;
    #12;
    chk("rst_we", we, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    // in_valid in IDLE is ignored
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("idle_valid_we", we, 0);
    chk("idle_valid_ready", in_ready, 0);

    // R format
    do_start(10'h010, 1);
    send_word(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hFFFF, 26'h3FFFFFF,
              32'h0022_1820, 0, 1'b0);

    // I then J with address wrap
    do_start(10'h3FF, 2);
    send_word(2'd1, 6'h08, 5'd0, 5'd8, 5'd31, 5'd31, 6'h3F, 16'd5, 26'h0,
              32'h2008_0005, 0, 1'b0);
    send_word(2'd2, 6'd2, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h010_0000,
              32'h0810_0000, 0, 1'b0);

    // count = 0
    do_start(10'h123, 0);
    tick();
    chk("zero_idle_we", we, 0);

    // Backpressure with ignored start; address/count must follow the original load
    do_start(10'h040, 2);
    send_word(2'd0, 6'd0, 5'd4, 5'd5, 5'd6, 5'd7, 6'h22, 16'h0, 26'h0,
              32'h0085_31E2, 5, 1'b1);
    send_word(2'd1, 6'h23, 5'd29, 5'd9, 5'd0, 5'd0, 6'd0, 16'h8000, 26'h0,
              32'h8FA9_8000, 1, 1'b1);

    // Illegal format
`ifdef INS_ASM_CHECK_EN
    ill_word = 32'h0000_0000;
`else
    ill_word = 32'hFC0A_BCDE;
`endif
    do_start(10'h200, 2);
    send_word(2'd3, 6'h3F, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1, 26'h0AB_CDE,
              ill_word, 0, 1'b0);
    send_word(2'd2, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h000_0004,
              32'h0C00_0004, 2, 1'b0);
    tick();
    chk("err_sticky_idle", err, exp_err);
    do_start(10'h000, 1);
    send_word(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h000_0001,
              32'h0800_0001, 0, 1'b0);

    // Randomized loads checked against the format rules
    for (int l = 0; l < 6; l++) begin
      n = int'($urandom_range(1, 5));
      do_start(AW'($urandom), n);
      for (int k = 0; k < n; k++) begin
        f = 2'($urandom); o = 6'($urandom); fn = 6'($urandom);
        s = 5'($urandom); t = 5'($urandom); d = 5'($urandom); sh = 5'($urandom);
        im = 16'($urandom); tg = 26'($urandom);
        send_word(f, o, s, t, d, sh, fn, im, tg, enc(f, o, s, t, d, sh, fn, im, tg),
                  int'($urandom_range(0, 2)), 1'($urandom));
      end
    end

    // Reset in the middle of a load, while a word is being written
    do_start(10'h005, 3);
    fmt = 2'd3; op = 6'h3F; target = 26'h1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mid_we", we, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_we", we, 0);
      chk("post_rst_done", done, 0);
      chk("post_rst_ready", in_ready, 0);
      chk("post_rst_busy", busy, 0);
    end
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
